trivium_rnd_source: RTL

- Randomness producer for the masked-gadget datapath. It is the supply end of the `rnd` interface that the HPC2 AND/ToF gadgets consume.
- Generates fresh bits from a Trivium keystream and presents `NRND` bits per cycle under a valid/ready handshake.
- Each word is delivered once and never reused, as the gadgets' security requires.
- Seeded at runtime through a separate seed handshake; sits between the top-level seed port and the S-box gadget array.

---
 rtl/trivium_rnd_source_if.sv | 23 ++
 rtl/trivium_rnd_source.sv | 100 ++++++++++
 2 files changed

// File: rtl/trivium_rnd_source_if.sv
// Seed and randomness handshake bundle for trivium_rnd_source.
// The producer (the Trivium block) takes the master view; the seed
// supplier / gadget consumer side takes the slave view.
interface trivium_rnd_source_if #(
   parameter int NRND = 64
);
   logic [159:0]    seed;
   logic            seed_valid;
   logic            seed_ready;
   logic [NRND-1:0] rnd;
   logic            rnd_valid;
   logic            rnd_ready;

   modport master (
      input  seed, seed_valid, rnd_ready,
      output seed_ready, rnd, rnd_valid
   );

   modport slave (
      output seed, seed_valid, rnd_ready,
      input  seed_ready, rnd, rnd_valid
   );
endinterface

// File: rtl/trivium_rnd_source.sv
// Trivium keystream randomness source feeding the masked gadget array.
// Register bit k holds Trivium state bit s(k+1). One step of NRND unrolled
// rounds per cycle; words are presented only in RUN and consumed exactly once.

// One Trivium round: keystream bit z and the shifted state.
module trivium_round (
   input  logic [287:0] s_in,
   output logic [287:0] s_out,
   output logic         z
);
   logic t1, t2, t3;
   logic t1f, t2f, t3f;

   assign t1  = s_in[65]  ^ s_in[92];
   assign t2  = s_in[161] ^ s_in[176];
   assign t3  = s_in[242] ^ s_in[287];
   assign z   = t1 ^ t2 ^ t3;
   assign t1f = t1 ^ (s_in[90]  & s_in[91])  ^ s_in[170];
   assign t2f = t2 ^ (s_in[174] & s_in[175]) ^ s_in[263];
   assign t3f = t3 ^ (s_in[285] & s_in[286]) ^ s_in[68];
   // three shift registers, each fed by the feedback of another
   assign s_out = {s_in[286:177], t2f, s_in[175:93], t1f, s_in[91:0], t3f};
endmodule

module trivium_rnd_source #(
   parameter int NRND          = 64,
   parameter int WARMUP_ROUNDS = 1152
) (
   input logic                clk,
   input logic                rst_n,
   trivium_rnd_source_if.master bus
);
   // warm-up is done in whole steps, so it may overshoot to a multiple of NRND
   localparam int WARM_STEPS = (WARMUP_ROUNDS + NRND - 1) / NRND;
   localparam int CW         = $clog2(WARM_STEPS + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WARM_STEPS);

   typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

   state_t              st_q, st_d;
   logic [287:0]        s_q, s_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NRND:0][287:0] chain;
   logic [NRND-1:0]     z;
   logic                run;

   assign chain[0] = s_q;

   for (genvar i = 0; i < NRND; i++) begin : g_round
      trivium_round u_round (
         .s_in  (chain[i]),
         .s_out (chain[i+1]),
         .z     (z[i])
      );
   end

   // Outputs depend only on registers; warm-up bits never leave the block.
   assign run            = (st_q == RUN);
   assign bus.rnd_valid  = run;
   assign bus.rnd        = run ? z : '0;
   assign bus.seed_ready = 1'b1;

   // Next state: a seed load wins over any step, including a same-cycle transfer.
   always_comb begin
      st_d  = st_q;
      s_d   = s_q;
      cnt_d = cnt_q;
      if (bus.seed_valid) begin
         s_d   = {3'b111, 108'b0, 4'b0, bus.seed[159:80], 13'b0, bus.seed[79:0]};
         cnt_d = CNT_INIT;
         st_d  = WARMUP;
      end else begin
         case (st_q)
            WARMUP: begin
               s_d   = chain[NRND];
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == 1) st_d = RUN;
            end
            RUN: begin
               // advance on every transfer so no word is presented twice
               if (bus.rnd_ready) s_d = chain[NRND];
            end
            default: ;
         endcase
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         s_q   <= '0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         s_q   <= s_d;
         cnt_q <= cnt_d;
      end
   end
endmodule
